// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first,
// repeated rep_cnt times with an optional single 0 bit between repeats.
module seq_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             gap_en,
  input  logic             abort,
  output logic             q_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [PAT_W-1:0] shreg_q;
  logic [PAT_W-1:0] pat_q;
  logic [BW-1:0]    bit_q;
  logic [CNT_W-1:0] rep_q;
  logic             gap_q;

  logic last_bit;
  logic q_d, valid_d, busy_d, done_d;

  assign last_bit = (bit_q == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (rep_cnt == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_bit) begin
          if (rep_q <= CNT_W'(1)) begin
            state_d = DONE;
          end else if (gap_q) begin
            state_d = GAP;
          end else begin
            state_d = SEND;
          end
        end
      end
      GAP: begin
        state_d = abort ? IDLE : SEND;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output flops track the state one cycle behind; abort blanks them at once.
  always_comb begin
    q_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      SEND: begin
        q_d     = shreg_q[PAT_W-1] & ~abort;
        valid_d = ~abort;
        busy_d  = ~abort;
      end
      GAP: begin
        valid_d = ~abort;
        busy_d  = ~abort;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        q_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_out   <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_out   <= q_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= DEF_PAT;
      pat_q   <= DEF_PAT;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q <= pat_in;
            pat_q   <= pat_in;
            rep_q   <= rep_cnt;
            gap_q   <= gap_en;
            bit_q   <= '0;
          end
        end
        SEND: begin
          if (!abort) begin
            if (last_bit) begin
              shreg_q <= pat_q;
              bit_q   <= '0;
              rep_q   <= (rep_q != '0) ? rep_q - CNT_W'(1) : '0;
            end else begin
              shreg_q <= shreg_q << 1;
              bit_q   <= bit_q + BW'(1);
            end
          end
        end
        default: begin
          bit_q <= bit_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Randomized self-checking bench for seq_gen against a
// stream-level reference model built from the transmit rules.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pat_in = '0;
  logic [3:0] rep_cnt = '0;
  logic       gap_en = 1'b0;
  logic       abort = 1'b0;
  logic       q_out, valid, busy, done;

  int checks = 0;
  int failures = 0;

  seq_gen dut (
    .clk(clk), .rst(rst), .start(start), .pat_in(pat_in),
    .rep_cnt(rep_cnt), .gap_en(gap_en), .abort(abort),
    .q_out(q_out), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected serial stream: reps of the pattern MSB-first, optional 0 between.
  function automatic void build(input logic [3:0] pat, input int rep,
                                input logic gap, output logic s[$]);
    s = {};
    for (int r = 0; r < rep; r++) begin
      for (int b = 3; b >= 0; b--) s.push_back(pat[b]);
      if (gap && r < rep - 1) s.push_back(1'b0);
    end
  endfunction

  // {valid,busy,done,q} expected at sample i after the start edge.
  function automatic logic [3:0] expect_at(input int i, input logic s[$]);
    int n;
    n = s.size();
    if (i >= 1 && i <= n) return {2'b11, 1'b0, s[i-1]};
    if (i == n + 1) return 4'b0010;
    return 4'b0000;
  endfunction

  task automatic run_xfer(input logic [3:0] pat, input int rep,
                          input logic gap, input bit scramble,
                          input string name, output int hits);
    logic s[$];
    logic [3:0] got, exp;
    logic [3:0] win;
    int n;
    build(pat, rep, gap, s);
    n = s.size();
    hits = 0;
    win = '0;
    @(negedge clk);
    pat_in = pat; rep_cnt = rep[3:0]; gap_en = gap; start = 1'b1;
    for (int i = 0; i <= n + 3; i++) begin
      @(negedge clk);
      got = {valid, busy, done, q_out};
      exp = expect_at(i, s);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", name, i, got, exp);
      end
      if (valid) begin
        win = {win[2:0], q_out};
        if (win == 4'b1011) hits++;
      end
      start = 1'b0;
      abort = 1'b0;
      if (scramble) begin
        if (i < n) start = 1'($urandom_range(0, 1));
        else abort = 1'($urandom_range(0, 1));
        pat_in = 4'($urandom);
        rep_cnt = 4'($urandom);
        gap_en = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({valid, busy, done, q_out} !== 4'b0000) begin
      failures++;
      $display("FAIL reset got=%b exp=0000", {valid, busy, done, q_out});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({valid, busy, done, q_out} !== 4'b0000) begin
        failures++;
        $display("FAIL idle_after_reset got=%b exp=0000",
                 {valid, busy, done, q_out});
      end
    end
  endtask

  task automatic test_fixed;
    int h;
    run_xfer(4'b1011, 1, 1'b0, 1'b0, "single", h);
    run_xfer(4'b1011, 3, 1'b1, 1'b0, "gap3", h);
    checks++;
    if (h !== 3) begin
      failures++;
      $display("FAIL loopback_hits got=%0d exp=3", h);
    end
    run_xfer(4'b1101, 2, 1'b0, 1'b0, "contig2", h);
    run_xfer(4'b0110, 0, 1'b1, 1'b0, "rep0", h);
    run_xfer(4'b1001, 15, 1'b1, 1'b0, "repmax", h);
  endtask

  task automatic test_ignore_inputs;
    int h;
    run_xfer(4'b1110, 2, 1'b0, 1'b1, "no_recapture", h);
  endtask

  task automatic test_random;
    int h;
    for (int t = 0; t < 25; t++) begin
      run_xfer(4'($urandom), $urandom_range(0, 6),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               "random", h);
    end
  endtask

  task automatic test_abort;
    logic s[$];
    logic [3:0] pat, got, exp;
    logic gap;
    int h;
    pat = 4'($urandom);
    gap = 1'($urandom_range(0, 1));
    build(pat, 2, gap, s);
    @(negedge clk);
    pat_in = pat; rep_cnt = 4'd2; gap_en = gap; start = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      got = {valid, busy, done, q_out};
      exp = (i <= 3) ? expect_at(i, s) : 4'b0000;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL abort cyc=%0d got=%b exp=%b", i, got, exp);
      end
      abort = (i == 3);
    end
    abort = 1'b0;
    run_xfer(4'b1011, 1, 1'b0, 1'b0, "after_abort", h);
  endtask

  task automatic test_async_reset;
    logic [3:0] got;
    @(negedge clk);
    pat_in = 4'b1111; rep_cnt = 4'd3; gap_en = 1'b0; start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    #1 rst = 1'b1;
    #1;
    got = {valid, busy, done, q_out};
    checks++;
    if (got !== 4'b0000) begin
      failures++;
      $display("FAIL async_rst got=%b exp=0000", got);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got = {valid, busy, done, q_out};
      checks++;
      if (got !== 4'b0000) begin
        failures++;
        $display("FAIL post_rst_idle cyc=%0d got=%b exp=0000", i, got);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic s[$];
    logic [3:0] pat, got, exp;
    logic gap;
    int rep, n;
    pat = 4'($urandom);
    rep = $urandom_range(1, 2);
    gap = 1'($urandom_range(0, 1));
    build(pat, rep, gap, s);
    n = s.size();
    @(negedge clk);
    pat_in = pat; rep_cnt = rep[3:0]; gap_en = gap; start = 1'b1;
    for (int i = 0; i <= 2 * n + 5; i++) begin
      @(negedge clk);
      got = {valid, busy, done, q_out};
      if (i <= n + 2) exp = expect_at(i, s);
      else exp = expect_at(i - (n + 2), s);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, got, exp);
      end
      if (i == n + 2) start = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_ignore_inputs();
    test_abort();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
Serial pattern transmitter, the counterpart to the team's Moore sequence detector. On a start request it captures a PAT_W-bit pattern and a repeat count. It then emits the pattern MSB-first on a one-bit serial line, one bit per clock, optionally with a single 0 gap bit between repetitions. Its output is wired straight to the detector's serial input for loopback and stimulus generation, and it reports busy/done status to a controller.

Parameters:
PAT_W, 4, pattern width in bits (>= 2)
CNT_W, 4, repeat-count width
DEF_PAT, 4'b1011, pattern loaded into the shift register at reset (informational only; never transmitted without start)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request transmission; sampled only in IDLE
pat_in  input  PAT_W  pattern to send; captured on accepted start
rep_cnt  input  CNT_W  number of pattern repetitions; captured on accepted start
gap_en  input  1  insert one 0 bit between repetitions; captured on accepted start
abort  input  1  synchronous cancel of an in-progress transmission
q_out  output  1  serial data bit
valid  output  1  q_out carries a transmitted bit this cycle
busy  output  1  transmission in progress (SEND or GAP)
done  output  1  one-cycle pulse at normal completion

Behaviour:
- Reset (async, immediate, also mid-transmission): state=IDLE, q_out=0, valid=0, busy=0, done=0, shreg=DEF_PAT, bit counter=0, rep counter=0, latched gap=0.
- Moore machine: all outputs are registered and depend only on state and the registered datapath. No combinational path from any input to any output.
- States: IDLE, SEND, GAP, DONE.
- IDLE: q_out=0, valid=0, busy=0, done=0.
  - start=1 at an edge: latch pat_in into shreg, rep_cnt into rep counter, gap_en into the gap flag. Clear the bit counter.
  - If rep_cnt==0, go to DONE. Otherwise go to SEND.
- SEND: q_out=shreg[PAT_W-1], valid=1, busy=1.
  - Each edge shifts shreg left by 1 and increments the bit counter.
  - On the edge that completes bit PAT_W-1, decrement the rep counter and reload shreg from a saved copy of the pattern.
  - If the remaining reps are 0, go to DONE. Else, if the gap flag is set, go to GAP; else stay in SEND with no idle cycle between repetitions.
- GAP: exactly one cycle, q_out=0, valid=1, busy=1, then SEND.
- DONE: exactly one cycle, done=1, busy=0, valid=0, q_out=0, then IDLE.
- Latency: start accepted at edge k puts the first bit on q_out after edge k+1.
- Total valid cycles = rep*PAT_W + (rep-1)*gap for rep>=1. Done asserts in the cycle after the last bit.
- start while not in IDLE: ignored, not queued.
- Changes to pat_in, rep_cnt or gap_en after capture have no effect on the current transmission.
- abort=1 at any edge in SEND or GAP: go to IDLE. No done pulse; q_out=0 and valid=0 from the next cycle.
  - abort in IDLE or DONE: no effect; DONE still pulses.
  - abort and start together in IDLE: start wins and abort is ignored.
- rep counter saturates at 0 (it never wraps). Maximum rep = 2^CNT_W-1.
- Back-to-back: start held high continuously gives a new transmission beginning on the edge after the DONE cycle's return to IDLE. The gap is IDLE for exactly one cycle.

Test Plan:
- Reset, then pat_in=1011, rep_cnt=1, gap_en=0, start for 1 cycle -> q_out=1,0,1,1 with valid=1 on 4 consecutive cycles starting 1 cycle after start; done=1 on the 5th cycle; busy low afterwards.
- pat_in=1011, rep_cnt=3, gap_en=1 -> valid stream 1011 0 1011 0 1011 (14 cycles), single done pulse. Loopback into the sequence detector: detector q asserts 3 times.
- pat_in=1101, rep_cnt=2, gap_en=0 -> 11011101 contiguous (8 cycles), no idle cycle between reps. rep_cnt=0 -> done one cycle after start, valid never asserted.
- Start re-pulsed and pat_in changed to 0000 during SEND of a rep=2 transfer -> original pattern continues unchanged; no second transmission.
- abort asserted on the 3rd bit of rep=2 -> valid/q_out 0 from the next cycle, state IDLE, done never pulses. A new start is then accepted normally.
- Async rst pulsed between clock edges mid-SEND -> all outputs 0 immediately, without waiting for a clock edge. After release, the block idles until start.
